// File: rtl/btn_event_ctrl_pkg.sv
// Shared definitions for the front-panel button event controller.
//   KIND_*  : evt_kind encodings (press, release, long, repeat)
//   P_*     : bit positions of the per-button pending-event flags
//   id_w()  : width of an event id for a given button count
package btn_evt_pkg;

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_RELEASE = 2'b01;
  localparam logic [1:0] KIND_LONG    = 2'b10;
  localparam logic [1:0] KIND_REPEAT  = 2'b11;

  localparam int unsigned P_PRESS = 0;
  localparam int unsigned P_REL   = 1;
  localparam int unsigned P_LONG  = 2;
  localparam int unsigned P_REP   = 3;

  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Event port of the button controller (valid/ready handshake).
//   evt_valid : event available          (master -> slave)
//   evt_ready : consumer accepts event   (slave -> master)
//   evt_id    : button index             (master -> slave)
//   evt_kind  : KIND_* encoding          (master -> slave)
// N_BTN must match the controller instance so evt_id widths agree.
interface btn_event_ctrl_if
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN = 4
) ();

  localparam int unsigned ID_W = id_w(N_BTN);

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [1:0]      evt_kind;

  modport master (output evt_valid, output evt_id, output evt_kind, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_kind, output evt_ready);

endinterface

// File: rtl/btn_event_ctrl_channel.sv
// One button channel: 2-FF synchroniser, debounce, hold timer, optional
// repeat timer, and the four pending-event flags.
//   clk, rst_n : clock, async active-low reset
//   raw_i      : raw button input (1 = pressed)
//   clr_i      : per-flag clear strobes from the arbiter (P_* positions)
//   level_o    : debounced level
//   pend_o     : pending flags (P_* positions)
//   drop_o     : an event was raised while its flag was already pending
// Macro BTN_AUTO_REPEAT_EN enables the repeat timer and repeat events.
module btn_channel
  import btn_evt_pkg::*;
#(
  parameter int unsigned DB_BITS   = 16,
  parameter int unsigned LONG_BITS = 24,
  parameter int unsigned REP_BITS  = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_i,
  input  logic [3:0] clr_i,
  output logic       level_o,
  output logic [3:0] pend_o,
  output logic       drop_o
);

  localparam logic [LONG_BITS-1:0] HOLD_LAST = {{(LONG_BITS-1){1'b1}}, 1'b0};

  logic                 sync1_q, sync2_q, level_q;
  logic [DB_BITS-1:0]   db_q;
  logic [LONG_BITS-1:0] hold_q;
  logic [3:0]           pend_q, pend_d, set_d;
  logic                 toggle, long_hit, rep_hit;

  assign toggle   = (sync2_q != level_q) && (&db_q);
  // The increment that reaches all-ones is the single long event per press.
  assign long_hit = level_q && (hold_q == HOLD_LAST);

`ifdef BTN_AUTO_REPEAT_EN
  logic [REP_BITS-1:0] rep_q;
  // Runs only once the hold timer has saturated; fires when it wraps.
  assign rep_hit = level_q && (&hold_q) && (&rep_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rep_q <= '0;
    else if (!level_q || long_hit) rep_q <= '0;
    else if (&hold_q)              rep_q <= rep_q + REP_BITS'(1);
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_comb begin
    set_d          = '0;
    set_d[P_PRESS] = toggle && !level_q;
    set_d[P_REL]   = toggle && level_q;
    set_d[P_LONG]  = long_hit;
    set_d[P_REP]   = rep_hit;
    pend_d         = set_d | (pend_q & ~clr_i);
  end

  assign drop_o  = |(set_d & pend_q & ~clr_i);
  assign level_o = level_q;
  assign pend_o  = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      db_q    <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        db_q <= '0;
      end else if (toggle) begin
        db_q    <= '0;
        level_q <= ~level_q;
      end else begin
        db_q <= db_q + DB_BITS'(1);
      end
      if (!level_q)      hold_q <= '0;
      else if (!(&hold_q)) hold_q <= hold_q + LONG_BITS'(1);
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Front-panel button controller: N_BTN debounced channels whose pending
// events share one valid/ready event port through round-robin arbitration.
//   clk, rst_n : clock, async active-low reset
//   btn_raw    : raw button inputs (1 = pressed)
//   btn_level  : debounced levels
//   evt        : event port (master modport: evt_valid/evt_id/evt_kind out, evt_ready in)
//   evt_ovf    : sticky flag, an event was dropped
//   ovf_clr    : synchronous clear of evt_ovf (a same-cycle drop wins)
// Macro BTN_AUTO_REPEAT_EN (in btn_channel) enables auto-repeat events.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN     = 4,
  parameter int unsigned DB_BITS   = 16,
  parameter int unsigned LONG_BITS = 24,
  parameter int unsigned REP_BITS  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn_raw,
  output logic [N_BTN-1:0]  btn_level,
  btn_event_ctrl_if.master  evt,
  output logic              evt_ovf,
  input  logic              ovf_clr
);

  localparam int unsigned ID_W = id_w(N_BTN);

  logic [3:0]      pend [N_BTN];
  logic [3:0]      clr  [N_BTN];
  logic [N_BTN-1:0] drop;

  logic            valid_q, ovf_q;
  logic [ID_W-1:0] id_q, rr_q, sel_id;
  logic [1:0]      kind_q, sel_kind;
  logic [1:0]      sel_bit;
  logic            found, load;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DB_BITS  (DB_BITS),
      .LONG_BITS(LONG_BITS),
      .REP_BITS (REP_BITS)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn_raw[g]),
      .clr_i  (clr[g]),
      .level_o(btn_level[g]),
      .pend_o (pend[g]),
      .drop_o (drop[g])
    );
  end

  assign load = !valid_q || evt.evt_ready;

  // Round-robin search starting at rr_q, then fixed kind priority in the winner.
  always_comb begin
    logic [ID_W-1:0] cand;
    found    = 1'b0;
    sel_id   = '0;
    sel_bit  = 2'(P_REL);
    sel_kind = KIND_RELEASE;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      int unsigned idx;
      idx = 32'(rr_q) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      cand = ID_W'(idx);
      if (!found && (|pend[cand])) begin
        found  = 1'b1;
        sel_id = cand;
      end
    end
    if (pend[sel_id][P_PRESS]) begin
      sel_bit  = 2'(P_PRESS);
      sel_kind = KIND_PRESS;
    end else if (pend[sel_id][P_LONG]) begin
      sel_bit  = 2'(P_LONG);
      sel_kind = KIND_LONG;
    end else if (pend[sel_id][P_REP]) begin
      sel_bit  = 2'(P_REP);
      sel_kind = KIND_REPEAT;
    end
    for (int unsigned c = 0; c < N_BTN; c++) clr[c] = '0;
    if (load && found) clr[sel_id][sel_bit] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      kind_q  <= '0;
      rr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (load) begin
        valid_q <= found;
        if (found) begin
          id_q   <= sel_id;
          kind_q <= sel_kind;
          rr_q   <= (32'(sel_id) == N_BTN - 1) ? '0 : sel_id + ID_W'(1);
        end
      end
      if (|drop)        ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign evt.evt_kind  = kind_q;
  assign evt_ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl (N_BTN=4, DB_BITS=3, LONG_BITS=5, REP_BITS=3).
// A level change appears 10 cycles after a raw step; its event 1 cycle later.
module tb_btn_event_ctrl;
  import btn_evt_pkg::*;

`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = '0;
  logic [3:0] btn_level;
  logic       evt_ovf;
  logic       ovf_clr = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  btn_event_ctrl_if #(.N_BTN(4)) evt_if ();

  btn_event_ctrl #(
    .N_BTN(4), .DB_BITS(3), .LONG_BITS(5), .REP_BITS(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .evt      (evt_if.master),
    .evt_ovf  (evt_ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] id,
                         input logic [1:0] kind);
    logic [4:0] obs, exp;
    obs = v ? {evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind}
            : {evt_if.evt_valid, 4'b0000};
    exp = {v, (v ? id : 2'b00), (v ? kind : 2'b00)};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed valid/id/kind %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    evt_if.evt_ready = 1'b1;

    // Reset state
    step(2);
    chk_evt("reset_evt", 1'b0, 2'd0, 2'd0);
    chk4("reset_level", btn_level, 4'b0000);
    chk1("reset_ovf", evt_ovf, 1'b0);
    chk4("reset_id_kind", {evt_if.evt_id, evt_if.evt_kind}, 4'b0000);
    rst_n = 1'b1;
    step(1);

    // 1: single press / release on button 2
    btn_raw[2] = 1'b1;
    step(9);
    chk4("t1_level_before", btn_level, 4'b0000);
    step(1);
    chk4("t1_level_after", btn_level, 4'b0100);
    chk_evt("t1_no_evt_yet", 1'b0, 2'd0, 2'd0);
    step(1);
    chk_evt("t1_press", 1'b1, 2'd2, KIND_PRESS);
    step(1);
    chk_evt("t1_press_once", 1'b0, 2'd0, 2'd0);
    step(8);
    btn_raw[2] = 1'b0;
    step(10);
    chk4("t1_level_rel", btn_level, 4'b0000);
    step(1);
    chk_evt("t1_release", 1'b1, 2'd2, KIND_RELEASE);
    step(1);
    chk_evt("t1_release_once", 1'b0, 2'd0, 2'd0);

    // 2: 6-cycle glitch on button 0 is filtered
    begin
      logic seen;
      seen = 1'b0;
      btn_raw[0] = 1'b1;
      for (int t = 0; t < 20; t++) begin
        step(1);
        if (t == 5) btn_raw[0] = 1'b0;
        seen = seen | evt_if.evt_valid | btn_level[0];
      end
      chk1("t2_glitch", seen, 1'b0);
    end

    // 3: long hold on button 1 (long at +42, repeats at +50/+58/+66 if enabled)
    btn_raw[1] = 1'b1;
    step(11);
    chk_evt("t3_press", 1'b1, 2'd1, KIND_PRESS);
    for (int t = 12; t <= 70; t++) begin
      step(1);
      if (t == 42)
        chk_evt("t3_long", 1'b1, 2'd1, KIND_LONG);
      else if (REP_EN && (t == 50 || t == 58 || t == 66))
        chk_evt("t3_repeat", 1'b1, 2'd1, KIND_REPEAT);
      else
        chk_evt("t3_idle", 1'b0, 2'd0, 2'd0);
      if (t == 60) btn_raw[1] = 1'b0;
    end
    step(1);
    chk_evt("t3_release", 1'b1, 2'd1, KIND_RELEASE);
    step(1);
    chk_evt("t3_after", 1'b0, 2'd0, 2'd0);

    // 4: simultaneous presses with a stalled consumer (reset first so RR starts at 0)
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    evt_if.evt_ready = 1'b0;
    btn_raw = 4'b1111;
    step(10);
    chk4("t4_level", btn_level, 4'b1111);
    step(1);
    chk_evt("t4_first", 1'b1, 2'd0, KIND_PRESS);
    for (int t = 12; t <= 22; t++) begin
      step(1);
      chk_evt("t4_stall_stable", 1'b1, 2'd0, KIND_PRESS);
    end
    evt_if.evt_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step(1);
      chk_evt("t4_press_seq", 1'b1, 2'(i), KIND_PRESS);
    end
    step(1);
    chk_evt("t4_drained", 1'b0, 2'd0, 2'd0);
    btn_raw = 4'b0000;
    step(10);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk_evt("t4_release_seq", 1'b1, 2'(i), KIND_RELEASE);
    end
    step(1);
    chk_evt("t4_rel_drained", 1'b0, 2'd0, 2'd0);

    // 5: overflow on button 3 while the consumer stalls
    evt_if.evt_ready = 1'b0;
    btn_raw[3] = 1'b1;
    step(11);
    chk_evt("t5_press1", 1'b1, 2'd3, KIND_PRESS);
    step(1);
    btn_raw[3] = 1'b0;
    step(12);
    btn_raw[3] = 1'b1;
    step(12);
    btn_raw[3] = 1'b0;
    step(9);
    chk1("t5_ovf_before", evt_ovf, 1'b0);
    step(1);
    chk1("t5_ovf_set", evt_ovf, 1'b1);
    chk_evt("t5_stall_hold", 1'b1, 2'd3, KIND_PRESS);
    ovf_clr = 1'b1;
    step(1);
    chk1("t5_ovf_cleared", evt_ovf, 1'b0);
    ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b1;
    step(1);
    chk_evt("t5_press2", 1'b1, 2'd3, KIND_PRESS);
    step(1);
    chk_evt("t5_release", 1'b1, 2'd3, KIND_RELEASE);
    step(1);
    chk_evt("t5_drained", 1'b0, 2'd0, 2'd0);

    // 6: reset during a stall discards the event; held button re-presses
    evt_if.evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    step(11);
    chk_evt("t6_stalled", 1'b1, 2'd2, KIND_PRESS);
    step(2);
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_valid", evt_if.evt_valid, 1'b0);
    chk4("t6_rst_id_kind", {evt_if.evt_id, evt_if.evt_kind}, 4'b0000);
    chk4("t6_rst_level", btn_level, 4'b0000);
    chk1("t6_rst_ovf", evt_ovf, 1'b0);
    step(2);
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    step(9);
    chk4("t6_level_before", btn_level, 4'b0000);
    step(1);
    chk4("t6_level_after", btn_level, 4'b0100);
    step(1);
    chk_evt("t6_repress", 1'b1, 2'd2, KIND_PRESS);
    btn_raw = 4'b0000;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
